// File: rtl/fir63_sampler_if.sv
// Sample/weight input and filter result bundle between the sampling front end,
// the FIR core and the LMS weight-update logic.
interface fir63_sampler_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 10,
    parameter int TAPS   = 64
);
    logic                          ready_in;
    logic signed [DATA_W-1:0]      signal_in;
    logic [TAPS-1:0][COEF_W-1:0]   weights_in;
    logic signed [DATA_W-1:0]      signal_out;
    logic                          done_out;
    logic signed [31:0]            norm_out;
    logic [$clog2(TAPS)-1:0]       offset_out;

    modport master (
        output ready_in, signal_in, weights_in,
        input  signal_out, done_out, norm_out, offset_out
    );

    modport slave (
        input  ready_in, signal_in, weights_in,
        output signal_out, done_out, norm_out, offset_out
    );
endinterface

// File: rtl/fir63_sampler.sv
// 64-tap serial-MAC FIR over a circular sample history, with a running
// sum-of-squares (norm) of the buffered samples for the LMS update logic.
module fir63_sampler #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 10,
    parameter int SHIFT  = 10
) (
    input  logic            clk_in,
    input  logic            rst_in,
    fir63_sampler_if.slave  bus
);
    localparam int TAPS   = 64;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = 32;
    localparam int SQ_W   = 2 * DATA_W;
    localparam int SUM_W  = 37;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(1 << (DATA_W - 1));
    localparam logic [SUM_W-1:0]        NORM_MAX = SUM_W'(32'h7fff_ffff);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state, state_next;
    logic                     emit;
    logic [5:0]               offset, tap, wr_idx, rd_idx;
    logic signed [DATA_W-1:0] sample [TAPS];
    logic signed [COEF_W-1:0] wlat   [TAPS];
    logic signed [ACC_W-1:0]  acc, acc_scaled;
    logic signed [PROD_W-1:0] prod;
    logic signed [SQ_W-1:0]   sq_new, sq_old;
    logic [SUM_W-1:0]         sumsq;
    logic signed [DATA_W-1:0] sat_val;

    assign wr_idx     = offset + 6'd1;
    assign rd_idx     = offset - tap;
    assign prod       = wlat[tap] * sample[rd_idx];
    assign sq_new     = bus.signal_in * bus.signal_in;
    assign sq_old     = sample[wr_idx] * sample[wr_idx];
    assign acc_scaled = acc >>> SHIFT;

    assign bus.offset_out = offset;
    assign bus.norm_out   = (sumsq > NORM_MAX) ? 32'sh7fff_ffff : $signed(sumsq[31:0]);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sat_val = acc_scaled[DATA_W-1:0];
        if (acc_scaled > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
        else if (acc_scaled < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    end

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        case (state)
            IDLE: state_next = IDLE;
            MAC:  if (tap == 6'd63) state_next = OUT;
            OUT: begin
                state_next = IDLE;
                emit       = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        // A new sample always restarts the MAC; the result in flight is dropped.
        if (bus.ready_in) begin
            state_next = MAC;
            emit       = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            // NOTE: the history and weight copy are reset because the norm and MAC assume a zeroed buffer.
            for (int i = 0; i < TAPS; i++) begin
                sample[i] <= '0;
                wlat[i]   <= '0;
            end
            offset         <= '1;
            tap            <= '0;
            acc            <= '0;
            sumsq          <= '0;
            bus.signal_out <= '0;
            bus.done_out   <= 1'b0;
        end else begin
            bus.done_out <= emit;
            if (emit) bus.signal_out <= sat_val;

            if (bus.ready_in) begin
                sample[wr_idx] <= bus.signal_in;
                offset         <= wr_idx;
                // Squares are non-negative; the sum tracks exactly the buffered samples.
                sumsq <= sumsq + {5'b0, sq_new} - {5'b0, sq_old};
                for (int i = 0; i < TAPS; i++) wlat[i] <= $signed(bus.weights_in[i]);
                acc <= '0;
                tap <= '0;
            end else if (state == MAC) begin
                acc <= acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
                tap <= tap + 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_fir63_sampler.sv
// Directed bench for fir63_sampler: reset, impulse response, weight latching,
// norm tracking and saturation, abort and mid-operation reset.
module tb_fir63_sampler;
    typedef logic [63:0][9:0] wvec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   done_count = 0;

    fir63_sampler_if bus ();

    fir63_sampler dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done_out === 1'b1) done_count++;

    function automatic wvec_t ramp(input int scale);
        wvec_t w;
        for (int i = 0; i < 64; i++) w[i] = 10'(scale * i);
        return w;
    endfunction

    function automatic wvec_t flat(input int v);
        wvec_t w;
        for (int i = 0; i < 64; i++) w[i] = 10'(v);
        return w;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Holds ready_in for n consecutive edges, optionally swaps weights chg_at cycles
    // after the last edge, then watches 127 cycles for the result.
    task automatic send(input logic signed [15:0] val, input int n, input wvec_t w,
                        input int chg_at, input wvec_t w_alt,
                        output int lat, output int nd, output logic signed [15:0] res);
        int c0;
        @(posedge clk);
        #1;
        c0             = done_count;
        bus.weights_in = w;
        bus.signal_in  = val;
        bus.ready_in   = 1'b1;
        repeat (n) @(posedge clk);
        #1 bus.ready_in = 1'b0;
        lat = -1;
        res = '0;
        for (int k = 1; k <= 127; k++) begin
            if (k == chg_at) bus.weights_in = w_alt;
            @(posedge clk);
            #1;
            if (bus.done_out === 1'b1 && lat < 0) begin
                lat = k;
                res = bus.signal_out;
            end
        end
        nd = done_count - c0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.signal_out !== 16'sd0) begin bad++; $display("FAIL reset_signal_out got=%0d want=0", bus.signal_out); end
        total++;
        if (bus.done_out !== 1'b0) begin bad++; $display("FAIL reset_done_out got=%b want=0", bus.done_out); end
        total++;
        if (bus.norm_out !== 32'sd0) begin bad++; $display("FAIL reset_norm_out got=%0d want=0", bus.norm_out); end
        total++;
        if (bus.offset_out !== 6'd63) begin bad++; $display("FAIL reset_offset_out got=%0d want=63", bus.offset_out); end
        #1 rst = 1'b0;
    endtask

    // Impulse of 1024 against weights scale*i walks the weights out one per sample.
    task automatic test_impulse(input int scale, input bit change_weights, input string name);
        int lat, nd;
        logic signed [15:0] res, exp;
        logic [5:0] exp_off;
        logic signed [31:0] exp_norm;
        do_reset();
        for (int k = 0; k < 65; k++) begin
            send((k == 0) ? 16'sd1024 : 16'sd0, 1, ramp(scale), change_weights ? 10 : -1, flat(300), lat, nd, res);
            exp      = (k < 64) ? 16'(scale * k) : 16'sd0;
            exp_off  = 6'(k % 64);
            exp_norm = (k < 64) ? 32'sd1048576 : 32'sd0;
            total++;
            if (res !== exp) begin bad++; $display("FAIL %s_out k=%0d got=%0d want=%0d", name, k, res, exp); end
            total++;
            if (lat != 65) begin bad++; $display("FAIL %s_latency k=%0d got=%0d want=65", name, k, lat); end
            total++;
            if (nd != 1) begin bad++; $display("FAIL %s_done_count k=%0d got=%0d want=1", name, k, nd); end
            total++;
            if (bus.offset_out !== exp_off) begin bad++; $display("FAIL %s_offset k=%0d got=%0d want=%0d", name, k, bus.offset_out, exp_off); end
            total++;
            if (bus.norm_out !== exp_norm) begin bad++; $display("FAIL %s_norm k=%0d got=%0d want=%0d", name, k, bus.norm_out, exp_norm); end
        end
    endtask

    task automatic test_norm();
        int lat, nd;
        logic signed [15:0] res;
        do_reset();
        send(16'sd3, 1, '0, -1, '0, lat, nd, res);
        total++;
        if (bus.norm_out !== 32'sd9) begin bad++; $display("FAIL norm_after_3 got=%0d want=9", bus.norm_out); end
        send(16'sd4, 1, '0, -1, '0, lat, nd, res);
        total++;
        if (bus.norm_out !== 32'sd25) begin bad++; $display("FAIL norm_after_4 got=%0d want=25", bus.norm_out); end
        send(16'sd0, 62, '0, -1, '0, lat, nd, res);
        total++;
        if (bus.norm_out !== 32'sd25) begin bad++; $display("FAIL norm_after_62_zeros got=%0d want=25", bus.norm_out); end
        send(16'sd0, 1, '0, -1, '0, lat, nd, res);
        total++;
        if (bus.norm_out !== 32'sd16) begin bad++; $display("FAIL norm_evict_3 got=%0d want=16", bus.norm_out); end
        send(16'sd0, 1, '0, -1, '0, lat, nd, res);
        total++;
        if (bus.norm_out !== 32'sd0) begin bad++; $display("FAIL norm_evict_4 got=%0d want=0", bus.norm_out); end
    endtask

    // Full-scale buffers with weights 511; bursts also exercise back-to-back aborts.
    task automatic test_saturation();
        int lat, nd;
        logic signed [15:0] res;
        do_reset();
        send(-16'sd32768, 1, flat(511), -1, '0, lat, nd, res);
        total++;
        if (bus.norm_out !== 32'sd1073741824) begin bad++; $display("FAIL sat_norm_one got=%0d want=1073741824", bus.norm_out); end
        total++;
        if (res !== -16'sd16352) begin bad++; $display("FAIL sat_out_one got=%0d want=-16352", res); end
        send(-16'sd32768, 1, flat(511), -1, '0, lat, nd, res);
        total++;
        if (bus.norm_out !== 32'sd2147483647) begin bad++; $display("FAIL sat_norm_two got=%0d want=2147483647", bus.norm_out); end
        total++;
        if (res !== -16'sd32704) begin bad++; $display("FAIL sat_out_two got=%0d want=-32704", res); end
        send(-16'sd32768, 62, flat(511), -1, '0, lat, nd, res);
        total++;
        if (res !== -16'sd32768) begin bad++; $display("FAIL sat_out_neg got=%0d want=-32768", res); end
        total++;
        if (lat != 65) begin bad++; $display("FAIL sat_neg_latency got=%0d want=65", lat); end
        total++;
        if (nd != 1) begin bad++; $display("FAIL back_to_back_done_count got=%0d want=1", nd); end
        total++;
        if (bus.norm_out !== 32'sd2147483647) begin bad++; $display("FAIL sat_norm_full got=%0d want=2147483647", bus.norm_out); end
        send(16'sd32767, 64, flat(511), -1, '0, lat, nd, res);
        total++;
        if (res !== 16'sd32767) begin bad++; $display("FAIL sat_out_pos got=%0d want=32767", res); end
        total++;
        if (nd != 1) begin bad++; $display("FAIL sat_pos_done_count got=%0d want=1", nd); end
        total++;
        if (bus.offset_out !== 6'd63) begin bad++; $display("FAIL sat_offset got=%0d want=63", bus.offset_out); end
    endtask

    // Second sample 20 cycles into the first MAC: only its own result appears.
    task automatic test_abort();
        int c0, lat;
        logic signed [15:0] res;
        do_reset();
        @(posedge clk);
        #1;
        c0             = done_count;
        bus.weights_in = flat(64);
        bus.signal_in  = 16'sd1024;
        bus.ready_in   = 1'b1;
        @(posedge clk);
        #1 bus.ready_in = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        bus.signal_in = 16'sd2048;
        bus.ready_in  = 1'b1;
        @(posedge clk);
        #1 bus.ready_in = 1'b0;
        lat = -1;
        res = '0;
        for (int k = 1; k <= 127; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_out === 1'b1 && lat < 0) begin
                lat = k;
                res = bus.signal_out;
            end
        end
        total++;
        if (lat != 65) begin bad++; $display("FAIL abort_latency got=%0d want=65", lat); end
        total++;
        if (res !== 16'sd192) begin bad++; $display("FAIL abort_out got=%0d want=192", res); end
        total++;
        if (done_count - c0 != 1) begin bad++; $display("FAIL abort_done_count got=%0d want=1", done_count - c0); end
    endtask

    task automatic test_reset_midop();
        int c0;
        @(posedge clk);
        #1;
        bus.signal_in = 16'sd500;
        bus.ready_in  = 1'b1;
        @(posedge clk);
        #1 bus.ready_in = 1'b0;
        repeat (30) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        c0 = done_count;
        total++;
        if (bus.offset_out !== 6'd63) begin bad++; $display("FAIL midop_offset got=%0d want=63", bus.offset_out); end
        total++;
        if (bus.norm_out !== 32'sd0) begin bad++; $display("FAIL midop_norm got=%0d want=0", bus.norm_out); end
        total++;
        if (bus.signal_out !== 16'sd0) begin bad++; $display("FAIL midop_signal_out got=%0d want=0", bus.signal_out); end
        #1 rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        total++;
        if (done_count != c0) begin bad++; $display("FAIL midop_spurious_done got=%0d want=0", done_count - c0); end
    endtask

    initial begin
        bus.ready_in   = 1'b0;
        bus.signal_in  = '0;
        bus.weights_in = '0;
        test_reset();
        test_impulse(1, 1'b0, "impulse");
        test_impulse(2, 1'b1, "weight_change");
        test_norm();
        test_saturation();
        test_abort();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
